morph_frame_sched: RTL and testbench

- Frame-level scheduler for the binary erode/dilate datapath (two cascaded morphology stages) in the object-tracker video pipe.
- Watches the input video timing (vs/hs/clken) and latches a software-requested operation only at frame boundaries, so a frame is never processed with mixed settings.
- Drives per-stage operation selects, and counts frames.
- Checks frame geometry against the configured size and flags sync loss.

---
 rtl/morph_frame_sched_pkg.sv | 53 +++++
 rtl/morph_frame_sched_geom.sv | 90 +++++++++
 rtl/morph_frame_sched.sv | 156 +++++++++++++++
 tb/tb_morph_frame_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_frame_sched_pkg.sv
// Shared definitions for the erode/dilate frame scheduler: mode and select codes,
// FSM state encoding, and small helpers used by the top and the geometry checker.
package morph_frame_sched_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_ERODE  = 2'b01,
    MODE_DILATE = 2'b10,
    MODE_OPEN   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_PASS   = 2'd0,
    SEL_ERODE  = 2'd1,
    SEL_DILATE = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  typedef struct packed {
    sel_e s0;
    sel_e s1;
  } sel_pair_t;

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Open = erode in the first stage, dilate in the second.
  function automatic sel_pair_t decode_mode(mode_e m);
    sel_pair_t p;
    p.s0 = SEL_PASS;
    p.s1 = SEL_PASS;
    case (m)
      MODE_ERODE:  p.s0 = SEL_ERODE;
      MODE_DILATE: p.s0 = SEL_DILATE;
      MODE_OPEN: begin
        p.s0 = SEL_ERODE;
        p.s1 = SEL_DILATE;
      end
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/morph_frame_sched_geom.sv
// Frame geometry checker: counts pixels per line and lines per frame inside a
// scheduled frame and raises a sticky size error on any mismatch.
module morph_geom_chk
  import morph_frame_sched_pkg::*;
#(
  parameter int IMG_W = 800,
  parameter int IMG_H = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic pre_clken,
  input  logic pre_hs,
  input  logic frame_start_i,
  input  logic frame_run_i,
  input  logic frame_close_i,
  input  logic err_clr_i,
  output logic size_err_o
);

  localparam logic [CNT_W-1:0] W_EXP = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_EXP = CNT_W'(IMG_H);

  logic             clken_q, clken_d;
  logic             hs_q, hs_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             size_err_q, size_err_d;
  logic             clken_fall;
  logic             err_set;
  logic [CNT_W-1:0] line_tot;

  // hsync is sampled for qualification only; line counting follows clken.
  logic unused_hs;
  assign unused_hs = hs_q;

  assign clken_fall = clken_q & ~pre_clken;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clken_d    = pre_clken;
    hs_d       = pre_hs;
    pix_d      = pix_q;
    line_d     = line_q;
    err_set    = 1'b0;
    line_tot   = line_q;

    if (frame_run_i) begin
      if (clken_fall) begin
        if (pix_q != W_EXP) err_set = 1'b1;
        line_tot = sat_inc(line_q);
      end
      if (frame_close_i && (line_tot != H_EXP)) err_set = 1'b1;
    end

    if (frame_start_i) begin
      pix_d  = '0;
      line_d = '0;
    end else if (frame_run_i) begin
      if (clken_fall) begin
        pix_d  = '0;
        line_d = line_tot;
      end else if (pre_clken) begin
        pix_d = sat_inc(pix_q);
      end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    size_err_d = err_set | (size_err_q & ~err_clr_i);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clken_q    <= 1'b0;
      hs_q       <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      size_err_q <= 1'b0;
    end else begin
      clken_q    <= clken_d;
      hs_q       <= hs_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      size_err_q <= size_err_d;
    end
  end

  assign size_err_o = size_err_q;

endmodule

// File: rtl/morph_frame_sched.sv
// Frame-level scheduler for the two-stage erode/dilate datapath: latches the
// requested mode only at vsync, drives stage selects, counts frames, watches sync.
module morph_frame_sched
  import morph_frame_sched_pkg::*;
#(
  parameter int          IMG_W       = 800,
  parameter int          IMG_H       = 600,
  parameter bit          VS_POL      = 1'b1,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_valid,
  input  logic        pre_vs,
  input  logic        pre_hs,
  input  logic        pre_clken,
  output logic [1:0]  stage0_sel,
  output logic [1:0]  stage1_sel,
  output logic [1:0]  active_mode,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        size_err,
  output logic        sync_lost
);

  state_e      state_q, state_d;
  logic        vs_act_q, vs_act_d;
  mode_e       pend_q, pend_d;
  mode_e       mode_q, mode_d;
  logic        fs_q, fs_d;
  logic        fd_q, fd_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic        slost_q, slost_d;

  logic        vs_act;
  logic        vs_edge;
  mode_e       load_mode;
  logic        tmo_hit;
  logic        frame_accept;
  logic        frame_run;
  logic        frame_close;
  sel_pair_t   sel_w;

  assign vs_act  = (pre_vs == VS_POL);
  assign vs_edge = vs_act & ~vs_act_q;

  // A strobe landing on the vsync edge applies to the frame that is starting.
  assign load_mode = cfg_valid ? mode_e'(cfg_mode) : pend_q;

  assign tmo_hit      = cfg_enable && (state_q != ST_IDLE) && !vs_edge &&
                        (tmo_q == TIMEOUT_CYC - 24'd1);
  assign frame_accept = cfg_enable && (state_q != ST_IDLE) && vs_edge;
  assign frame_close  = frame_accept && (state_q == ST_ACTIVE);
  assign frame_run    = cfg_enable && (state_q == ST_ACTIVE) && !tmo_hit;

  always_comb begin
    state_d  = state_q;
    vs_act_d = vs_act;
    pend_d   = cfg_valid ? mode_e'(cfg_mode) : pend_q;
    mode_d   = mode_q;
    fs_d     = 1'b0;
    fd_d     = 1'b0;
    fcnt_d   = fcnt_q;
    tmo_d    = tmo_q;
    slost_d  = slost_q & ~cfg_valid;

    if (!cfg_enable) begin
      // Disable truncates the frame silently: no done pulse, count restarts.
      state_d = ST_IDLE;
      mode_d  = MODE_BYPASS;
      fcnt_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          tmo_d   = '0;
        end
        ST_ARMED, ST_ACTIVE: begin
          if (vs_edge) begin
            fs_d    = 1'b1;
            mode_d  = load_mode;
            tmo_d   = '0;
            state_d = ST_ACTIVE;
            if (state_q == ST_ACTIVE) begin
              fd_d   = 1'b1;
              fcnt_d = fcnt_q + 16'd1;
            end
          end else if (tmo_hit) begin
            slost_d = 1'b1;
            state_d = ST_ARMED;
            mode_d  = MODE_BYPASS;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 24'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control and status flops exist here, so every one takes a reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vs_act_q <= 1'b0;
      pend_q   <= MODE_BYPASS;
      mode_q   <= MODE_BYPASS;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
      fcnt_q   <= '0;
      tmo_q    <= '0;
      slost_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_act_q <= vs_act_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      fs_q     <= fs_d;
      fd_q     <= fd_d;
      fcnt_q   <= fcnt_d;
      tmo_q    <= tmo_d;
      slost_q  <= slost_d;
    end
  end

  morph_geom_chk #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_geom (
    .clk           (clk),
    .rst           (rst),
    .pre_clken     (pre_clken),
    .pre_hs        (pre_hs),
    .frame_start_i (frame_accept),
    .frame_run_i   (frame_run),
    .frame_close_i (frame_close),
    .err_clr_i     (cfg_valid),
    .size_err_o    (size_err)
  );

  assign sel_w       = decode_mode(mode_q);
  assign stage0_sel  = sel_w.s0;
  assign stage1_sel  = sel_w.s1;
  assign active_mode = mode_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_cnt   = fcnt_q;
  assign sync_lost   = slost_q;

endmodule

// File: tb/tb_morph_frame_sched.sv
// Self-checking bench for morph_frame_sched: frame-level reference model compared
// every cycle, plus literal expectations at the key scheduling points.
module tb_morph_frame_sched;

  localparam int          W = 8;
  localparam int          H = 4;
  localparam logic [23:0] T = 24'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic        cfg_valid = 1'b0;
  logic        pre_vs = 1'b0;
  logic        pre_hs = 1'b0;
  logic        pre_clken = 1'b0;
  logic [1:0]  stage0_sel, stage1_sel, active_mode;
  logic        frame_start, frame_done, size_err, sync_lost;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_cfg = 1'b0;

  always #5 clk = ~clk;

  morph_frame_sched #(
    .IMG_W       (W),
    .IMG_H       (H),
    .VS_POL      (1'b1),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_enable  (cfg_enable),
    .cfg_mode    (cfg_mode),
    .cfg_valid   (cfg_valid),
    .pre_vs      (pre_vs),
    .pre_hs      (pre_hs),
    .pre_clken   (pre_clken),
    .stage0_sel  (stage0_sel),
    .stage1_sel  (stage1_sel),
    .active_mode (active_mode),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .size_err    (size_err),
    .sync_lost   (sync_lost)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode-to-select table: returns {sel1, sel0}.
  function automatic logic [3:0] sels_for(input logic [1:0] m);
    case (m)
      2'b00:   return {2'd0, 2'd0};
      2'b01:   return {2'd0, 2'd1};
      2'b10:   return {2'd0, 2'd2};
      default: return {2'd2, 2'd1};
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic        m_on, m_in, m_serr, m_slost, m_fs, m_fd, m_vs_prev, m_ck_prev;
  logic [1:0]  m_mode, m_pend;
  logic [15:0] m_cnt;
  int          m_since, m_pix, m_lines;

  always @(posedge clk or posedge rst) begin : model
    logic on, inf, serr, slost, fs, fd, vs_new, fall;
    logic [1:0] mode, pend;
    logic [15:0] cnt;
    int since, pix, lines, tot;
    if (rst) begin
      m_on <= 0; m_in <= 0; m_serr <= 0; m_slost <= 0; m_fs <= 0; m_fd <= 0;
      m_vs_prev <= 0; m_ck_prev <= 0; m_mode <= 0; m_pend <= 0; m_cnt <= 0;
      m_since <= 0; m_pix <= 0; m_lines <= 0;
    end else begin
      on = m_on; inf = m_in; mode = m_mode; cnt = m_cnt;
      since = m_since; pix = m_pix; lines = m_lines;
      vs_new = pre_vs && !m_vs_prev;
      fall   = m_ck_prev && !pre_clken;
      pend   = cfg_valid ? cfg_mode : m_pend;
      serr   = m_serr && !cfg_valid;
      slost  = m_slost && !cfg_valid;
      fs = 0; fd = 0;
      if (!cfg_enable) begin
        on = 0; inf = 0; mode = 0; cnt = 0; since = 0;
      end else if (!on) begin
        on = 1; since = 0;
      end else if (vs_new) begin
        if (inf) begin
          tot = lines;
          if (fall) begin
            if (pix != W) serr = 1;
            tot = (lines < 4095) ? lines + 1 : lines;
          end
          if (tot != H) serr = 1;
          fd = 1;
          cnt = cnt + 16'd1;
        end
        fs = 1; inf = 1; mode = pend; pix = 0; lines = 0; since = 0;
      end else if (since == int'(T) - 1) begin
        slost = 1; inf = 0; mode = 0; since = 0;
      end else begin
        since++;
        if (inf) begin
          if (fall) begin
            if (pix != W) serr = 1;
            lines = (lines < 4095) ? lines + 1 : lines;
            pix = 0;
          end else if (pre_clken) begin
            pix = (pix < 4095) ? pix + 1 : pix;
          end
        end
      end
      m_on <= on; m_in <= inf; m_serr <= serr; m_slost <= slost; m_fs <= fs; m_fd <= fd;
      m_vs_prev <= pre_vs; m_ck_prev <= pre_clken; m_mode <= mode; m_pend <= pend;
      m_cnt <= cnt; m_since <= since; m_pix <= pix; m_lines <= lines;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("frame_start", frame_start, m_fs);
      check("frame_done", frame_done, m_fd);
      check("active_mode", active_mode, m_mode);
      check("stage0_sel", stage0_sel, sels_for(m_mode) & 4'h3);
      check("stage1_sel", stage1_sel, sels_for(m_mode) >> 2);
      check("frame_cnt", frame_cnt, m_cnt);
      check("size_err", size_err, m_serr);
      check("sync_lost", sync_lost, m_slost);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cfg_valid = rnd_cfg && ($urandom_range(0, 11) == 0);
    if (cfg_valid) cfg_mode = 2'($urandom_range(0, 3));
  endtask

  task automatic vs_rise();
    pre_vs = 1'b1;
    tick();
  endtask

  task automatic vs_tail();
    tick();
    pre_vs = 1'b0;
    repeat ($urandom_range(2, 4)) tick();
  endtask

  task automatic drive_lines(input int nlines, input int bad_line, input int bad_len);
    for (int l = 0; l < nlines; l++) begin
      pre_hs = 1'b1;
      tick();
      pre_hs = 1'b0;
      tick();
      pre_clken = 1'b1;
      repeat ((l == bad_line) ? bad_len : W) tick();
      pre_clken = 1'b0;
      repeat ($urandom_range(2, 4)) tick();
    end
  endtask

  task automatic strobe(input logic [1:0] m);
    cfg_mode = m;
    cfg_valid = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel0"}, stage0_sel, 0);
    check({tag, "_sel1"}, stage1_sel, 0);
    check({tag, "_mode"}, active_mode, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
    check({tag, "_serr"}, size_err, 0);
    check({tag, "_slost"}, sync_lost, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    int c0;
    int nl;
    int bl;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // First frame, open mode
    tick();
    cfg_enable = 1'b1;
    strobe(2'b11);
    check("pre_edge_fs", frame_start, 0);
    vs_rise();
    check("fs_latency", frame_start, 1);
    check("open_sel0", stage0_sel, 1);
    check("open_sel1", stage1_sel, 2);
    check("open_mode", active_mode, 3);
    vs_tail();
    drive_lines(2, -1, 0);
    strobe(2'b10);
    check("mode_held_midframe", active_mode, 3);
    drive_lines(2, -1, 0);
    vs_rise();
    check("close1_fd", frame_done, 1);
    check("close1_fs", frame_start, 1);
    check("close1_cnt", frame_cnt, 1);
    check("close1_serr", size_err, 0);
    check("dilate_mode", active_mode, 2);
    check("dilate_sel0", stage0_sel, 2);
    check("dilate_sel1", stage1_sel, 0);
    vs_tail();

    // Short line, clear, then a 5-line frame
    drive_lines(4, 1, 7);
    check("short_line_err", size_err, 1);
    strobe(2'b10);
    check("err_cleared", size_err, 0);
    vs_rise();
    vs_tail();
    drive_lines(5, -1, 0);
    check("five_lines_before_close", size_err, 0);
    vs_rise();
    check("five_lines_at_close", size_err, 1);
    vs_tail();

    // Randomized frames with random config strobes
    rnd_cfg = 1'b1;
    for (int f = 0; f < 25; f++) begin
      nl = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : H;
      bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      drive_lines(nl, bl, $urandom_range(6, 9));
      vs_rise();
      vs_tail();
    end
    rnd_cfg = 1'b0;
    drive_lines(H, -1, 0);

    // Sync loss: one frame start, then vsync stops
    strobe(2'b01);
    vs_rise();
    c0 = cyc;
    check("tmo_fs", frame_start, 1);
    check("tmo_slost_before", sync_lost, 0);
    vs_tail();
    drive_lines(H, -1, 0);
    while (!sync_lost && (cyc - c0) < 300) tick();
    check("tmo_cycles", 16'(cyc - c0), 16'(T));
    check("tmo_sel0", stage0_sel, 0);
    check("tmo_mode", active_mode, 0);
    vs_rise();
    check("after_tmo_fs", frame_start, 1);
    check("after_tmo_fd", frame_done, 0);
    check("after_tmo_sel0", stage0_sel, 1);
    vs_tail();

    // Disable mid-frame, then re-enable
    drive_lines(2, -1, 0);
    cfg_enable = 1'b0;
    tick();
    check("dis_sel0", stage0_sel, 0);
    check("dis_cnt", frame_cnt, 0);
    drive_lines(2, -1, 0);
    vs_rise();
    check("dis_fs", frame_start, 0);
    check("dis_fd", frame_done, 0);
    vs_tail();
    cfg_enable = 1'b1;
    tick();
    drive_lines(2, -1, 0);
    vs_rise();
    check("reen_fs", frame_start, 1);
    check("reen_fd", frame_done, 0);
    vs_tail();
    drive_lines(H, -1, 0);
    vs_rise();
    check("reen_close_fd", frame_done, 1);
    check("reen_close_cnt", frame_cnt, 1);
    vs_tail();

    // Asynchronous reset mid-frame, then resume
    drive_lines(2, -1, 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    #10;
    rst = 1'b0;
    tick();
    strobe(2'b11);
    drive_lines(1, -1, 0);
    vs_rise();
    check("resume_fs", frame_start, 1);
    check("resume_fd", frame_done, 0);
    check("resume_cnt", frame_cnt, 0);
    vs_tail();
    drive_lines(H, -1, 0);
    vs_rise();
    check("resume_close_cnt", frame_cnt, 1);
    vs_tail();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
